// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences fetch/decode/execute/writeback over a
// shared instruction/data memory port, bounds memory wait states with a
// watchdog, and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             iord_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic [1:0]       pc_src_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic [3:0]       state_o,
  output logic             instr_done_o,
  output logic             illegal_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q;

  logic       mem_phase;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a;
  logic [2:0] alu_op;
  logic       reg_write, reg_dst, mem_to_reg;
  logic       instr_done, illegal, bus_err;

  // Per-state datapath control decode, next-state selection and watchdog.
  always_comb begin
    state_d    = state_q;
    mem_phase  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    wait_d     = wait_q;

    case (state_q)
      S_FETCH: begin
        mem_phase = 1'b1;
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready_i) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (instr_op_i)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_R:             state_d = S_R_EXEC;
          OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (instr_op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_phase = 1'b1;
        mem_req   = 1'b1;
        iord      = 1'b1;
        if (mem_ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_phase = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        iord      = 1'b1;
        if (mem_ready_i) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (instr_op_i == OP_SLTI) ? 3'b011 : 3'b000;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b001;
        pc_src     = 2'b01;
        pc_write   = (instr_op_i == OP_BNE) ? ~zero_i : zero_i;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Writes in memory states only happen with mem_ready_i=1, so an abort
    // (which requires mem_ready_i=0) never coincides with a write.
    if (mem_phase && !mem_ready_i && (wait_q == WAIT_LIMIT)) begin
      bus_err = 1'b1;
      state_d = S_FETCH;
    end

    if (bus_err || (state_d != state_q)) begin
      wait_d = '0;
    end else if (mem_phase && !mem_ready_i) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // State, watchdog and retire-counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (instr_done) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Reset forces every output low within the same cycle.
  always_comb begin
    mem_req_o    = mem_req    & ~rst_i;
    mem_we_o     = mem_we     & ~rst_i;
    iord_o       = iord       & ~rst_i;
    ir_write_o   = ir_write   & ~rst_i;
    pc_write_o   = pc_write   & ~rst_i;
    pc_src_o     = rst_i ? 2'b00 : pc_src;
    alu_src_a_o  = alu_src_a  & ~rst_i;
    alu_src_b_o  = rst_i ? 2'b00 : alu_src_b;
    alu_op_o     = rst_i ? 3'b000 : alu_op;
    reg_write_o  = reg_write  & ~rst_i;
    reg_dst_o    = reg_dst    & ~rst_i;
    mem_to_reg_o = mem_to_reg & ~rst_i;
    state_o      = rst_i ? 4'd0 : state_q;
    instr_done_o = instr_done & ~rst_i;
    illegal_o    = illegal    & ~rst_i;
    bus_err_o    = bus_err    & ~rst_i;
    instr_cnt_o  = rst_i ? '0 : cnt_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver issues instructions with
// random wait states and pushes the expected end-of-instruction event; a
// monitor accumulates each instruction's trace and compares on every event.
module tb_multicycle_ctrl;

  localparam int unsigned MAXW = 4;
  localparam int unsigned CW   = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic          clk = 1'b0;
  logic          rst_i, zero_i, mem_ready_i;
  logic [5:0]    instr_op_i;
  logic          mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o;
  logic [1:0]    pc_src_o, alu_src_b_o;
  logic          alu_src_a_o;
  logic [2:0]    alu_op_o;
  logic          reg_write_o, reg_dst_o, mem_to_reg_o;
  logic [3:0]    state_o;
  logic          instr_done_o, illegal_o, bus_err_o;
  logic [CW-1:0] instr_cnt_o;
  logic [26:0]   all_out;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .iord_o(iord_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
    .pc_src_o(pc_src_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .state_o(state_o), .instr_done_o(instr_done_o),
    .illegal_o(illegal_o), .bus_err_o(bus_err_o), .instr_cnt_o(instr_cnt_o)
  );

  assign all_out = {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
                    alu_src_a_o, alu_src_b_o, alu_op_o, reg_write_o, reg_dst_o,
                    mem_to_reg_o, state_o, instr_done_o, illegal_o, bus_err_o, instr_cnt_o};

  // kind: 1 retire, 2 illegal, 3 bus error. path: visited state codes after a leading 1.
  typedef struct {
    int unsigned   kind;
    int unsigned   lat;
    logic [23:0]   path;
    logic [14:0]   sig;
    int unsigned   irw;
    int unsigned   pcw;
    int unsigned   rw;
    logic [13:0]   masks;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  bit          mon_en = 1'b0;
  int unsigned retired = 0;
  logic [5:0]  legal [8] = '{OP_R, OP_ADDI, OP_SLTI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_J};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Control signature of the event cycle.
  function automatic logic [14:0] sg(input logic rw, input logic rd, input logic m2r,
                                     input logic pcw, input logic [1:0] pcs, input logic we,
                                     input logic req, input logic io, input logic a,
                                     input logic [1:0] b, input logic [2:0] op);
    return {rw, rd, m2r, pcw, pcs, we, req, io, a, b, op};
  endfunction

  // Sets of alu_op / alu_src_b / alu_src_a values seen over one instruction.
  function automatic logic [13:0] mk(input logic [7:0] o, input logic [3:0] b, input logic [1:0] a);
    return {o, b, a};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    for (int i = 0; i < 8; i++) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // w cycles not ready, then one ready cycle unless w exceeds the watchdog limit.
  task automatic mem_access(input int unsigned w);
    for (int unsigned k = 0; k < w; k++) begin
      mem_ready_i = 1'b0;
      step();
    end
    if (w <= MAXW) begin
      mem_ready_i = 1'b1;
      step();
    end
  endtask

  task automatic idle();
    mem_ready_i = 1'($urandom_range(0, 1));
    step();
  endtask

  task automatic run_instr(input logic [5:0] op, input bit z, input bit fab,
                           input int unsigned fw, input int unsigned dw);
    exp_t          e;
    logic [CW-1:0] c;
    bit            dok;
    c          = CW'(retired);
    dok        = (dw <= MAXW);
    instr_op_i = op;
    zero_i     = z;
    if (fab) begin
      e.kind = 3; e.lat = MAXW + 1; e.path = 24'h10;
      e.sig = sg(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 3'b000);
      e.irw = 0; e.pcw = 0; e.rw = 0; e.masks = mk(8'h01, 4'h2, 2'h1); e.cnt = c;
      sb.push_back(e);
    end
    e.kind = 1; e.irw = 1; e.pcw = 1; e.rw = 0; e.cnt = c;
    case (op)
      OP_R: begin
        e.lat = fw + 4; e.path = 24'h10167; e.rw = 1; e.masks = mk(8'h05, 4'hB, 2'h3);
        e.sig = sg(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
      end
      OP_ADDI, OP_SLTI: begin
        e.lat = fw + 4; e.path = 24'h10189; e.rw = 1;
        e.masks = mk((op == OP_SLTI) ? 8'h09 : 8'h01, 4'hF, 2'h3);
        e.sig = sg(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
      end
      OP_BEQ, OP_BNE: begin
        e.lat = fw + 3; e.path = 24'h101A; e.masks = mk(8'h03, 4'hB, 2'h3);
        e.pcw = ((op == OP_BEQ) == z) ? 2 : 1;
        e.sig = sg(1'b0, 1'b0, 1'b0, (op == OP_BEQ) == z, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b001);
      end
      OP_J: begin
        e.lat = fw + 3; e.path = 24'h101B; e.pcw = 2; e.masks = mk(8'h01, 4'hB, 2'h1);
        e.sig = sg(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
      end
      OP_LW: begin
        e.masks = mk(8'h01, 4'hF, 2'h3);
        if (dok) begin
          e.lat = fw + dw + 5; e.path = 24'h101234; e.rw = 1;
          e.sig = sg(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
        end else begin
          e.kind = 3; e.lat = fw + MAXW + 4; e.path = 24'h10123;
          e.sig = sg(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000);
        end
      end
      OP_SW: begin
        e.masks = mk(8'h01, 4'hF, 2'h3); e.path = 24'h10125;
        e.sig = sg(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000);
        if (dok) e.lat = fw + dw + 4;
        else begin e.kind = 3; e.lat = fw + MAXW + 4; end
      end
      default: begin
        e.kind = 2; e.lat = fw + 2; e.path = 24'h101; e.masks = mk(8'h01, 4'hA, 2'h1);
        e.sig = sg(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b000);
      end
    endcase
    sb.push_back(e);
    if (e.kind == 1) retired++;

    if (fab) mem_access(MAXW + 1);
    mem_access(fw);
    idle();
    case (op)
      OP_R, OP_ADDI, OP_SLTI: begin idle(); idle(); end
      OP_BEQ, OP_BNE, OP_J:   idle();
      OP_LW: begin idle(); mem_access(dw); if (dok) idle(); end
      OP_SW: begin idle(); mem_access(dw); end
      default: ;
    endcase
  endtask

  // Monitor: accumulate the trace of each instruction, compare on its end event.
  exp_t        m_e;
  logic [23:0] m_path;
  logic [3:0]  m_last;
  logic [13:0] m_msk;
  bit          m_first = 1'b1;
  int unsigned m_lat, m_irw, m_pcw, m_rw, m_kind;

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!mon_en) m_first = 1'b1;
      else begin
        if (m_first) begin
          m_path = 24'h1; m_last = 4'hF; m_msk = '0;
          m_lat = 0; m_irw = 0; m_pcw = 0; m_rw = 0; m_first = 1'b0;
        end
        if (state_o != m_last) m_path = {m_path[19:0], state_o};
        m_last = state_o;
        m_lat++;
        if (ir_write_o)  m_irw++;
        if (pc_write_o)  m_pcw++;
        if (reg_write_o) m_rw++;
        m_msk[13:6] = m_msk[13:6] | (8'd1 << alu_op_o);
        m_msk[5:2]  = m_msk[5:2]  | (4'd1 << alu_src_b_o);
        m_msk[1:0]  = m_msk[1:0]  | (2'd1 << alu_src_a_o);
        if (instr_done_o || illegal_o || bus_err_o) begin
          if (sb.size() == 0) begin
            check("unexpected_event", 32'({instr_done_o, illegal_o, bus_err_o}), 32'd0);
          end else begin
            m_e    = sb.pop_front();
            m_kind = instr_done_o ? 1 : (illegal_o ? 2 : 3);
            check("event_onehot", 32'($countones({instr_done_o, illegal_o, bus_err_o})), 32'd1);
            check("event_kind",   m_kind,       m_e.kind);
            check("latency",      m_lat,        m_e.lat);
            check("state_path",   32'(m_path),  32'(m_e.path));
            check("event_ctrl",   32'({reg_write_o, reg_dst_o, mem_to_reg_o, pc_write_o, pc_src_o,
                                       mem_we_o, mem_req_o, iord_o, alu_src_a_o, alu_src_b_o,
                                       alu_op_o}), 32'(m_e.sig));
            check("ir_writes",    m_irw,        m_e.irw);
            check("pc_writes",    m_pcw,        m_e.pcw);
            check("reg_writes",   m_rw,         m_e.rw);
            check("alu_ctrl_set", 32'(m_msk),   32'(m_e.masks));
            check("instr_cnt",    32'(instr_cnt_o), 32'(m_e.cnt));
          end
          m_first = 1'b1;
        end
      end
    end
  end

  // Driver: directed scenarios, random instruction mix, mid-access reset.
  initial begin
    logic [5:0]  op;
    bit          z, fab;
    int unsigned fw, dw;
    rst_i = 1'b1; mem_ready_i = 1'b1; instr_op_i = OP_LW; zero_i = 1'b1;
    repeat (3) step();
    #1;
    check("reset_outputs_zero", 32'(all_out), 32'd0);
    rst_i  = 1'b0;
    mon_en = 1'b1;
    #1;
    check("post_reset_state", 32'(state_o), 32'd0);
    check("post_reset_req",   32'(mem_req_o), 32'd1);

    run_instr(OP_R,    1'b0, 1'b0, 0, 0);
    run_instr(OP_LW,   1'b0, 1'b0, 0, 0);
    run_instr(OP_SW,   1'b0, 1'b0, 0, 0);
    run_instr(OP_BEQ,  1'b1, 1'b0, 0, 0);
    run_instr(OP_BNE,  1'b1, 1'b0, 0, 0);
    run_instr(OP_ADDI, 1'b0, 1'b0, 3, 0);
    run_instr(OP_LW,   1'b0, 1'b0, 0, MAXW + 1);
    run_instr(6'b111111, 1'b0, 1'b0, 0, 0);
    run_instr(OP_SLTI, 1'b0, 1'b1, MAXW, 0);
    run_instr(OP_SW,   1'b0, 1'b0, 1, MAXW);
    run_instr(OP_J,    1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 9) op = legal[$urandom_range(0, 7)];
      else begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      z   = 1'($urandom_range(0, 1));
      fab = ($urandom_range(0, 9) == 0);
      fw  = ($urandom_range(0, 4) == 0) ? MAXW : $urandom_range(0, 2);
      dw  = ($urandom_range(0, 7) == 0) ? MAXW + 1 : $urandom_range(0, MAXW);
      run_instr(op, z, fab, fw, dw);
    end
    check("scoreboard_drained", sb.size(), 32'd0);
    check("final_instr_cnt", 32'(instr_cnt_o), 32'(CW'(retired)));

    if (CW'(retired) == '0) run_instr(OP_J, 1'b0, 1'b0, 0, 0);
    mon_en = 1'b0;
    instr_op_i = OP_SW;
    mem_access(0);
    idle();
    idle();
    mem_ready_i = 1'b0;
    step();
    mem_ready_i = 1'b0;
    step();
    #1;
    check("memwr_wait_state", 32'(state_o), 32'd5);
    check("memwr_wait_we",    32'(mem_we_o), 32'd1);
    check("cnt_before_reset", 32'(instr_cnt_o), 32'(CW'(retired)));
    rst_i = 1'b1;
    #1;
    check("reset_drops_req", 32'(mem_req_o), 32'd0);
    check("reset_forces_zero", 32'(all_out), 32'd0);
    step();
    rst_i = 1'b0;
    #1;
    check("after_reset_state", 32'(state_o), 32'd0);
    check("after_reset_req",   32'(mem_req_o), 32'd1);
    check("after_reset_we",    32'(mem_we_o), 32'd0);
    check("after_reset_cnt",   32'(instr_cnt_o), 32'd0);

    retired = 0;
    mon_en  = 1'b1;
    run_instr(OP_R, 1'b0, 1'b0, 0, 0);
    check("scoreboard_drained_end", sb.size(), 32'd0);
    check("cnt_after_one", 32'(instr_cnt_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
